// File: rtl/nodetable_pkg.sv
// Shared types and defaults for the node-information table memory controller.
package nodetable_pkg;

    localparam int WORD_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 6;
    localparam int DEPTH_DEF      = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        CLEAR  = 2'd3
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/nodetable_mem_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is taken.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt
);

    // ptr_r = 0 favours requester 0 on contention
    logic ptr_r;

    // Grant selection from current requests and pointer
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_r ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Pointer register: favour the requester that was not just granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= 1'b0;
        end else if (upd && (gnt != 2'b00)) begin
            ptr_r <= gnt[0];
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/nodetable_mem_ctrl.sv
// Sequencer/arbiter for the single-port node table bank with clear sweep.
// Optional conflict counter enabled by defining NODETABLE_CONFLICT_CNT_EN.
module nodetable_mem_ctrl
    import nodetable_pkg::*;
#(
    parameter int                    WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int                    DEPTH      = DEPTH_DEF,
    parameter logic [WORD_WIDTH-1:0] CLR_VALUE  = {WORD_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  clr_start,
    output logic                  clr_busy,
    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic [ADDR_WIDTH-1:0] r0_index,
    input  logic [WORD_WIDTH-1:0] r0_wdata,
    output logic                  r0_gnt,
    output logic                  r0_rvalid,
    output logic [WORD_WIDTH-1:0] r0_rdata,
    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic [ADDR_WIDTH-1:0] r1_index,
    input  logic [WORD_WIDTH-1:0] r1_wdata,
    output logic                  r1_gnt,
    output logic                  r1_rvalid,
    output logic [WORD_WIDTH-1:0] r1_rdata,
`ifdef NODETABLE_CONFLICT_CNT_EN
    output logic [15:0]           conflict_cnt,
`endif
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_index,
    output logic [WORD_WIDTH-1:0] mem_data_in,
    input  logic [WORD_WIDTH-1:0] mem_data_out
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    state_t                state_r, state_nxt;
    logic                  clr_pend_r, pend_nxt;
    logic                  win_id_r, win_nxt;
    logic                  lat_we_r, we_nxt;
    logic                  mem_wr_en_r, wr_en_nxt;
    logic [ADDR_WIDTH-1:0] mem_index_r, index_nxt;
    logic [WORD_WIDTH-1:0] mem_data_in_r, data_nxt;
    logic                  clr_busy_r, busy_nxt;
    logic                  r0_gnt_r, gnt0_nxt, r1_gnt_r, gnt1_nxt;
    logic                  r0_rvalid_r, rv0_nxt, r1_rvalid_r, rv1_nxt;
    logic [WORD_WIDTH-1:0] r0_rdata_r, rd0_nxt, r1_rdata_r, rd1_nxt;
    logic [1:0]            arb_gnt_s;
    logic                  arb_upd_s;
    logic                  clr_go_s;
    logic                  sel_we_s;
    logic [ADDR_WIDTH-1:0] sel_index_s;
    logic [WORD_WIDTH-1:0] sel_wdata_s;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (nrst),
        .req   ({r1_req, r0_req}),
        .upd   (arb_upd_s),
        .gnt   (arb_gnt_s)
    );

    assign sel_we_s    = arb_gnt_s[1] ? r1_we    : r0_we;
    assign sel_index_s = arb_gnt_s[1] ? r1_index : r0_index;
    assign sel_wdata_s = arb_gnt_s[1] ? r1_wdata : r0_wdata;

    // Next-state and next-output decode; bus values are computed one cycle early and registered
    always_comb begin
        state_nxt = state_r;
        pend_nxt  = clr_pend_r;
        win_nxt   = win_id_r;
        we_nxt    = lat_we_r;
        wr_en_nxt = 1'b0;
        index_nxt = mem_index_r;
        data_nxt  = mem_data_in_r;
        busy_nxt  = 1'b0;
        gnt0_nxt  = 1'b0;
        gnt1_nxt  = 1'b0;
        rv0_nxt   = 1'b0;
        rv1_nxt   = 1'b0;
        rd0_nxt   = r0_rdata_r;
        rd1_nxt   = r1_rdata_r;
        arb_upd_s = 1'b0;
        clr_go_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (clr_start || clr_pend_r) begin
                    state_nxt = CLEAR;
                    pend_nxt  = 1'b0;
                    clr_go_s  = 1'b1;
                    wr_en_nxt = 1'b1;
                    index_nxt = {ADDR_WIDTH{1'b0}};
                    data_nxt  = CLR_VALUE;
                    busy_nxt  = 1'b1;
                end else if (arb_gnt_s != 2'b00) begin
                    state_nxt = ACCESS;
                    arb_upd_s = 1'b1;
                    win_nxt   = arb_gnt_s[1] ? REQ1 : REQ0;
                    we_nxt    = sel_we_s;
                    wr_en_nxt = sel_we_s;
                    index_nxt = sel_index_s;
                    data_nxt  = sel_wdata_s;
                    gnt0_nxt  = arb_gnt_s[0];
                    gnt1_nxt  = arb_gnt_s[1];
                end else begin
                    state_nxt = IDLE;
                end
            end
            ACCESS: begin
                if (clr_start) begin
                    pend_nxt = 1'b1;
                end else begin
                    pend_nxt = clr_pend_r;
                end
                state_nxt = lat_we_r ? IDLE : RDWAIT;
            end
            RDWAIT: begin
                if (clr_start) begin
                    pend_nxt = 1'b1;
                end else begin
                    pend_nxt = clr_pend_r;
                end
                state_nxt = IDLE;
                if (win_id_r == REQ1) begin
                    rd1_nxt = mem_data_out;
                    rv1_nxt = 1'b1;
                end else begin
                    rd0_nxt = mem_data_out;
                    rv0_nxt = 1'b1;
                end
            end
            CLEAR: begin
                // Counter sits at the last index once the sweep is done
                if (mem_index_r == LAST_IDX) begin
                    state_nxt = IDLE;
                end else begin
                    wr_en_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                    index_nxt = mem_index_r + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r       <= IDLE;
            clr_pend_r    <= 1'b0;
            win_id_r      <= REQ0;
            lat_we_r      <= 1'b0;
            mem_wr_en_r   <= 1'b0;
            mem_index_r   <= {ADDR_WIDTH{1'b0}};
            mem_data_in_r <= {WORD_WIDTH{1'b0}};
            clr_busy_r    <= 1'b0;
            r0_gnt_r      <= 1'b0;
            r1_gnt_r      <= 1'b0;
            r0_rvalid_r   <= 1'b0;
            r1_rvalid_r   <= 1'b0;
            r0_rdata_r    <= {WORD_WIDTH{1'b0}};
            r1_rdata_r    <= {WORD_WIDTH{1'b0}};
        end else begin
            state_r       <= state_nxt;
            clr_pend_r    <= pend_nxt;
            win_id_r      <= win_nxt;
            lat_we_r      <= we_nxt;
            mem_wr_en_r   <= wr_en_nxt;
            mem_index_r   <= index_nxt;
            mem_data_in_r <= data_nxt;
            clr_busy_r    <= busy_nxt;
            r0_gnt_r      <= gnt0_nxt;
            r1_gnt_r      <= gnt1_nxt;
            r0_rvalid_r   <= rv0_nxt;
            r1_rvalid_r   <= rv1_nxt;
            r0_rdata_r    <= rd0_nxt;
            r1_rdata_r    <= rd1_nxt;
        end
    end

`ifdef NODETABLE_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt_r;

    // Saturating count of IDLE cycles with both requesters contending
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            conflict_cnt_r <= 16'h0000;
        end else if (clr_go_s) begin
            conflict_cnt_r <= 16'h0000;
        end else if ((state_r == IDLE) && r0_req && r1_req && (conflict_cnt_r != 16'hFFFF)) begin
            conflict_cnt_r <= conflict_cnt_r + 16'h0001;
        end else begin
            conflict_cnt_r <= conflict_cnt_r;
        end
    end

    assign conflict_cnt = conflict_cnt_r;
`endif

    assign clr_busy    = clr_busy_r;
    assign r0_gnt      = r0_gnt_r;
    assign r1_gnt      = r1_gnt_r;
    assign r0_rvalid   = r0_rvalid_r;
    assign r1_rvalid   = r1_rvalid_r;
    assign r0_rdata    = r0_rdata_r;
    assign r1_rdata    = r1_rdata_r;
    assign mem_wr_en   = mem_wr_en_r;
    assign mem_index   = mem_index_r;
    assign mem_data_in = mem_data_in_r;

endmodule
